// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS-subset CPU: sequences fetch/decode/execute
// and Moore-decodes all datapath enables. Optional addi support: MULTICYCLE_CONTROL_ADDI_EN.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    ,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_t r_state;
  state_t w_dec_state;
  logic   w_supported;
  logic   w_pc_write, w_mem_read, w_ir_write, w_mem_write;
  logic   w_reg_write, w_pc_write_cond, w_instr_done, w_illegal;

  always_comb begin
    w_supported = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                  (opcode == OP_BEQ) || (opcode == OP_J);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    if (opcode == OP_ADDI) w_supported = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:      r_state <= S_R_EXEC;
            OP_LW, OP_SW:  r_state <= S_MEM_ADDR;
            OP_BEQ:        r_state <= S_BRANCH;
            OP_J:          r_state <= S_JUMP;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
            OP_ADDI:       r_state <= S_ADDI_EXEC;
`endif
            default:       r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  r_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:    r_state <= S_MEM_WB;
        S_R_EXEC:    r_state <= S_R_WB;
`ifdef MULTICYCLE_CONTROL_ADDI_EN
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
`endif
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // Under reset the decode looks like FETCH so the mux selects settle early;
  // every strobe that could change architectural state is then masked below.
  assign w_dec_state = reset ? S_FETCH : r_state;

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    i_or_d          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    mem_to_reg      = 1'b0;
    reg_dst         = 1'b0;
    w_reg_write     = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 2'b00;
    pc_source       = 2'b00;
    w_instr_done    = 1'b0;
    w_illegal       = 1'b0;
    case (w_dec_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = 1'b1;
        alu_src_b  = 2'b01;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        alu_src_b    = 2'b11;
        w_illegal    = ~w_supported;
        w_instr_done = ~w_supported;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        i_or_d     = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        mem_to_reg   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write  = 1'b1;
        i_or_d       = 1'b1;
        w_instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_dst      = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        w_pc_write_cond = 1'b1;
        pc_source       = 2'b01;
        w_instr_done    = 1'b1;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        pc_source    = 2'b10;
        w_instr_done = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign pc_write      = w_pc_write      & ~reset;
  assign pc_write_cond = w_pc_write_cond & ~reset;
  assign mem_read      = w_mem_read      & ~reset;
  assign mem_write     = w_mem_write     & ~reset;
  assign ir_write      = w_ir_write      & ~reset;
  assign reg_write     = w_reg_write     & ~reset;
  assign instr_done    = w_instr_done    & ~reset;
  assign illegal       = w_illegal       & ~reset;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction state-sequence model plus
// per-state output table, with random and directed resets (incl. abort in MEM_RD).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal(illegal),
    .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: states still to come for the instruction in flight
  logic [3:0] exp_q[$];

  task automatic load_seq(input logic [5:0] op);
    exp_q.push_back(4'd1);
    case (op)
      6'b000000: begin exp_q.push_back(4'd6); exp_q.push_back(4'd7); end
      6'b100011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
      6'b101011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
      6'b000100: exp_q.push_back(4'd8);
      6'b000010: exp_q.push_back(4'd9);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
      6'b001000: begin exp_q.push_back(4'd10); exp_q.push_back(4'd11); end
`endif
      default: ;
    endcase
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    logic ok;
    ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
         (op == 6'b000100) || (op == 6'b000010);
`ifdef MULTICYCLE_CONTROL_ADDI_EN
    if (op == 6'b001000) ok = 1'b1;
`endif
    return ok;
  endfunction

  // packing: pw,pwc,iod,mr,mw,irw,m2r,rdst,rw,asa,asb[2],aop[2],psrc[2],done,ill
  function automatic logic [18:0] exp_outs(input logic [3:0] s, input logic [5:0] op, input logic rst);
    logic pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, done, ill;
    logic [1:0] asb, aop, psrc;
    logic [3:0] row;
    {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    row = rst ? 4'd0 : s;
    case (row)
      4'd0: begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
      4'd1: begin asb = 2'b11; ill = !is_legal(op); done = !is_legal(op); end
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mr = 1; iod = 1; end
      4'd4: begin rw = 1; m2r = 1; done = 1; end
      4'd5: begin mw = 1; iod = 1; done = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rdst = 1; rw = 1; done = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      4'd9: begin pw = 1; psrc = 2'b10; done = 1; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: begin rw = 1; done = 1; end
      default: ;
    endcase
    if (rst) begin pw = 0; mr = 0; irw = 0; end
    return {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done, ill};
  endfunction

  logic [18:0] got_outs;
  assign got_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, instr_done, illegal};

  logic [5:0] dir_ops[$] = '{6'b100011, 6'b101011, 6'b000100, 6'b000000, 6'b000010,
                             6'b111111, 6'b001000, 6'b100011, 6'b100011};
  logic [5:0] known_ops[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b000010, 6'b001000, 6'b111111, 6'b100011};

  initial begin
    logic [3:0] cur;
    logic [5:0] op;
    int rst_left;
    int n_instr;
    bit memrd_reset_done;
    rst_left = 3;
    n_instr = 0;
    memrd_reset_done = 0;
    cur = 4'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      // model step, using the reset level the DUT saw at this edge
      if (reset) begin
        cur = 4'd0;
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        cur = 4'd0;
      end else begin
        cur = exp_q.pop_front();
      end
      // driver: reset scheduling
      if (rst_left == 0) begin
        if (cur == 4'd3 && n_instr == 9 && !memrd_reset_done) begin
          rst_left = 2;
          memrd_reset_done = 1;
        end else if (n_instr > 9 && $urandom_range(0, 63) == 0) begin
          rst_left = $urandom_range(1, 3);
        end
      end
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      // driver: new instruction enters the IR during FETCH
      if (!reset && cur == 4'd0) begin
        if (dir_ops.size() > 0) op = dir_ops.pop_front();
        else if ($urandom_range(0, 3) != 0) op = known_ops[$urandom_range(0, 7)];
        else op = 6'($urandom_range(0, 63));
        opcode = op;
        n_instr++;
        load_seq(op);
      end
      #1;
      check_eq("state", {28'd0, state}, {28'd0, cur});
      check_eq("outputs", {13'd0, got_outs}, {13'd0, exp_outs(cur, opcode, reset)});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
